// File: rtl/hex_tx_pkg.sv
// rtl/hex_tx_pkg.sv - shared state encoding and ASCII constants for the hex word transmitter
package hex_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } hex_tx_state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_SP      = 8'h20;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

endpackage

// File: rtl/hex_digit_enc.sv
// rtl/hex_digit_enc.sv - maps one 4-bit nibble to its ASCII hex digit
module hex_digit_enc #(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    import hex_tx_pkg::*;

    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;

    // Digits 0-9 offset from '0', digits A-F offset from the selected letter case
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_word_tx.sv
// rtl/hex_word_tx.sv - prints a word as ASCII hex to a UART; HEX_WORD_TX_CRLF_EN appends CR/LF
module hex_word_tx #(
    parameter int         NIBBLES   = 4,
    parameter bit         UPPERCASE = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h20
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_enable,
    input  logic                   tx_busy,
    output logic                   busy,
    output logic                   word_done
);
    import hex_tx_pkg::*;

    localparam int HAS_SEP = (SEP_CHAR != 8'h00) ? 1 : 0;
`ifdef HEX_WORD_TX_CRLF_EN
    localparam int N_TAIL  = HAS_SEP + 2;
`else
    localparam int N_TAIL  = HAS_SEP;
`endif
    localparam int N_CHARS = NIBBLES + N_TAIL;
    // Sized for NIBBLES+3 positions so the index never wraps inside a word
    localparam int IDX_W   = $clog2(NIBBLES + 4);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CHARS - 1);
    localparam logic [IDX_W-1:0] DIGIT_END = IDX_W'(NIBBLES);

    hex_tx_state_t          state_q, state_d;
    logic [4*NIBBLES-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   word_done_q, word_done_d;

    logic [7:0]             digit_char;
    logic [7:0]             tail_char;
    logic [7:0]             cur_char;

    // The current digit is always the top nibble; the register shifts left as digits complete
    hex_digit_enc #(
        .UPPERCASE (UPPERCASE)
    ) u_digit_enc (
        .nibble (shift_q[4*NIBBLES-1 -: 4]),
        .ascii  (digit_char)
    );

    // Select the separator / line-ending byte for index positions past the digits
    always_comb begin
        tail_char = 8'h00;
        if (HAS_SEP != 0 && idx_q == DIGIT_END) begin
            tail_char = SEP_CHAR;
        end
`ifdef HEX_WORD_TX_CRLF_EN
        else if (idx_q == IDX_W'(NIBBLES + HAS_SEP)) begin
            tail_char = ASCII_CR;
        end else if (idx_q == IDX_W'(NIBBLES + HAS_SEP + 1)) begin
            tail_char = ASCII_LF;
        end
`endif
    end

    // Outputs depend only on registered state and index, so tx_data holds through ISSUE and WAIT
    always_comb begin
        cur_char  = (idx_q < DIGIT_END) ? digit_char : tail_char;
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        tx_enable = (state_q == ST_ISSUE);
        tx_data   = (state_q == ST_IDLE) ? 8'h00 : cur_char;
        word_done = word_done_q;
    end

    // Next-state: accept in IDLE, request in ISSUE, wait for the UART to finish in WAIT
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        word_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tx_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        word_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ISSUE;
                        if (idx_q < DIGIT_END) begin
                            shift_d = shift_q << 4;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight word
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: tb/tb_hex_word_tx.sv
// tb/tb_hex_word_tx.sv - self-checking bench for hex_word_tx against a string-formatting reference
module tb_hex_word_tx;

    logic        CLK = 1'b0;
    logic        RST;
    always #5 CLK = ~CLK;

    logic [15:0] a_in_data;
    logic        a_in_valid, a_in_ready, a_tx_enable, a_tx_busy, a_busy, a_word_done;
    logic [7:0]  a_tx_data;

    logic [7:0]  b_in_data;
    logic        b_in_valid, b_in_ready, b_tx_enable, b_tx_busy, b_busy, b_word_done;
    logic [7:0]  b_tx_data;

    hex_word_tx dut_a (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .tx_data   (a_tx_data),
        .tx_enable (a_tx_enable),
        .tx_busy   (a_tx_busy),
        .busy      (a_busy),
        .word_done (a_word_done)
    );

    hex_word_tx #(
        .NIBBLES   (2),
        .UPPERCASE (1'b0),
        .SEP_CHAR  (8'h00)
    ) dut_b (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .tx_data   (b_tx_data),
        .tx_enable (b_tx_enable),
        .tx_busy   (b_tx_busy),
        .busy      (b_busy),
        .word_done (b_word_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART models and observation state
    int          a_cnt = 0, b_cnt = 0;
    int          a_len = 10, b_len = 2;
    bit          a_force = 0;
    logic [7:0]  a_obs[$], b_obs[$];
    logic [15:0] a_acc[$];
    logic [7:0]  b_acc[$];
    int          a_wd = 0, b_wd = 0;
    int          a_en_cycles = 0;
    int          inv_rdy_err = 0, inv_idle_err = 0, inv_stab_err = 0, wd_dbl = 0;
    bit          a_wd_prev = 0, b_wd_prev = 0, a_prev_busy = 0, a_prev_en = 0;
    logic [7:0]  a_prev_data = 0;

    // Handshake sampled at the accepting edge, where inputs are settled
    initial begin
        forever begin
            @(posedge CLK);
            if (!RST && a_in_valid && a_in_ready) a_acc.push_back(a_in_data);
            if (!RST && b_in_valid && b_in_ready) b_acc.push_back(b_in_data);
        end
    end

    initial begin
        a_tx_busy = 1'b0;
        b_tx_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                a_cnt = 0;
                b_cnt = 0;
            end else begin
                if (a_tx_enable) a_en_cycles++;
                if (a_tx_enable && !a_tx_busy) begin
                    a_obs.push_back(a_tx_data);
                    a_cnt = a_len;
                end else if (a_cnt > 0) a_cnt--;
                if (b_tx_enable && !b_tx_busy) begin
                    b_obs.push_back(b_tx_data);
                    b_cnt = b_len;
                end else if (b_cnt > 0) b_cnt--;
                if (a_word_done) a_wd++;
                if (b_word_done) b_wd++;
                if ((a_word_done && a_wd_prev) || (b_word_done && b_wd_prev)) wd_dbl++;
                if (a_in_ready == a_busy || b_in_ready == b_busy) inv_rdy_err++;
                if (!a_busy && (a_tx_enable || a_tx_data != 8'h00)) inv_idle_err++;
                if (a_busy && a_prev_busy && a_tx_data != a_prev_data && !(a_tx_enable && !a_prev_en))
                    inv_stab_err++;
            end
            a_wd_prev   = a_word_done;
            b_wd_prev   = b_word_done;
            a_prev_busy = a_busy;
            a_prev_en   = a_tx_enable;
            a_prev_data = a_tx_data;
            a_tx_busy   = (a_cnt > 0) || a_force;
            b_tx_busy   = (b_cnt > 0);
        end
    end

    // Reference: printf-style hex text of each accepted word, plus the configured tail
    task automatic compare_a(input string tag, input int skip);
        logic [7:0] exp[$];
        string s;
        foreach (a_acc[k]) begin
            s = $sformatf("%h", a_acc[k]);
            s = s.toupper();
            for (int i = 0; i < 4; i++) exp.push_back(8'(s[i]));
            exp.push_back(8'h20);
`ifdef HEX_WORD_TX_CRLF_EN
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
`endif
        end
        for (int i = 0; i < skip; i++) void'(exp.pop_front());
        check_eq({tag, "_nbytes"}, a_obs.size(), exp.size());
        check_eq({tag, "_words"}, a_wd, a_acc.size());
        for (int i = 0; i < exp.size() && i < a_obs.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), a_obs[i], exp[i]);
        a_obs.delete();
        a_acc.delete();
        a_wd = 0;
    endtask

    task automatic compare_b(input string tag);
        logic [7:0] exp[$];
        string s;
        foreach (b_acc[k]) begin
            s = $sformatf("%h", b_acc[k]);
            for (int i = 0; i < 2; i++) exp.push_back(8'(s[i]));
`ifdef HEX_WORD_TX_CRLF_EN
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
`endif
        end
        check_eq({tag, "_nbytes"}, b_obs.size(), exp.size());
        check_eq({tag, "_words"}, b_wd, b_acc.size());
        for (int i = 0; i < exp.size() && i < b_obs.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), b_obs[i], exp[i]);
        b_obs.delete();
        b_acc.delete();
        b_wd = 0;
    endtask

    task automatic send_a(input logic [15:0] w);
        int t = 0;
        while (!a_in_ready && t < 20000) begin
            @(negedge CLK);
            t++;
        end
        a_in_data  = w;
        a_in_valid = 1'b1;
        @(negedge CLK);
        check_eq("en_at_t1", a_tx_enable, 1);
        check_eq("ready_low_after_accept", a_in_ready, 0);
        a_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((a_busy || b_busy || a_in_valid || b_in_valid) && t < 20000) begin
            @(negedge CLK);
            t++;
        end
        check_eq({tag, "_idle"}, a_busy | b_busy, 0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int t, en0, en_hold, chg;
        logic [7:0] held;
        RST = 1'b1;
        a_in_valid = 0; a_in_data = 0; b_in_valid = 0; b_in_data = 0;
        repeat (2) @(negedge CLK);
        a_in_valid = 1; a_in_data = 16'hFFFF; b_in_valid = 1; b_in_data = 8'hFF;
        repeat (3) begin
            @(negedge CLK);
            check_eq("rst_no_accept_a", a_busy, 0);
            check_eq("rst_no_accept_b", b_busy, 0);
        end
        a_in_valid = 0; b_in_valid = 0;
        check_eq("rst_ready", a_in_ready, 1);
        check_eq("rst_tx_enable", a_tx_enable, 0);
        check_eq("rst_tx_data", a_tx_data, 0);
        check_eq("rst_word_done", a_word_done, 0);
        RST = 1'b0;
        @(negedge CLK);

        // BEEF with a 10-cycle UART
        a_len = 10;
        send_a(16'hBEEF);
        wait_idle("beef");
        compare_a("beef", 0);

        // Leading zeros and hex letters
        send_a(16'h00FF);
        wait_idle("00ff");
        compare_a("00ff", 0);

        // Lowercase, 2 nibbles, no separator
        b_in_data = 8'h0A; b_in_valid = 1; t = 0;
        while (b_acc.size() == 0 && t < 100) begin @(negedge CLK); t++; end
        b_in_valid = 0;
        wait_idle("b0a");
        compare_b("b0a");

        // in_valid held across two words
        a_len = 3;
        a_in_data = 16'h1234; a_in_valid = 1; t = 0;
        while (!a_busy && t < 100) begin @(negedge CLK); t++; end
        a_in_data = 16'hABCD; t = 0;
        while (a_acc.size() < 2 && t < 5000) begin @(negedge CLK); t++; end
        a_in_valid = 0;
        wait_idle("b2b");
        compare_a("b2b", 0);

        // Reset after two characters of BEEF
        a_len = 10;
        send_a(16'hBEEF);
        t = 0;
        while (a_obs.size() < 2 && t < 5000) begin @(negedge CLK); t++; end
        RST = 1'b1;
        @(negedge CLK);
        check_eq("mid_rst_enable", a_tx_enable, 0);
        check_eq("mid_rst_ready", a_in_ready, 1);
        check_eq("mid_rst_busy", a_busy, 0);
        RST = 1'b0;
        a_obs.delete(); a_acc.delete(); a_wd = 0;
        send_a(16'h0001);
        wait_idle("after_rst");
        compare_a("after_rst", 0);

        // UART already busy on ISSUE entry: single-cycle request, first char lost
        a_len = 4;
        a_force = 1;
        repeat (2) @(negedge CLK);
        en0 = a_en_cycles;
        send_a(16'h1234);
        repeat (20) @(negedge CLK);
        check_eq("busy_on_entry_en_cycles", a_en_cycles - en0, 1);
        a_force = 0;
        wait_idle("busy_entry");
        compare_a("busy_entry", 1);

        // UART busy held for 1000 cycles during WAIT
        a_len = 10;
        send_a(16'hC0DE);
        t = 0;
        while (!(a_obs.size() >= 1 && a_busy && !a_tx_enable) && t < 5000) begin @(negedge CLK); t++; end
        a_force = 1;
        @(negedge CLK);
        held = a_tx_data; en_hold = 0; chg = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (a_tx_enable) en_hold++;
            if (a_tx_data != held) chg++;
        end
        check_eq("hold_enable", en_hold, 0);
        check_eq("hold_data", chg, 0);
        a_force = 0;
        wait_idle("hold");
        compare_a("hold", 0);

        // Random words, UART speeds and gaps
        for (int n = 0; n < 40; n++) begin
            a_len = $urandom_range(1, 6);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            send_a(16'($urandom));
        end
        wait_idle("rand_a");
        compare_a("rand_a", 0);

        // Random data on a continuously valid input
        b_in_valid = 1;
        repeat (300) begin
            b_in_data = 8'($urandom);
            @(negedge CLK);
        end
        b_in_valid = 0;
        wait_idle("rand_b");
        compare_b("rand_b");

        check_eq("inv_ready_vs_busy", inv_rdy_err, 0);
        check_eq("inv_idle_outputs", inv_idle_err, 0);
        check_eq("inv_tx_data_stable", inv_stab_err, 0);
        check_eq("inv_word_done_width", wd_dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hex_word_tx.md
HEX_WORD_TX -- requirements
Module: hex_word_tx

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of hex digits per word (1..16).
REQ-002 SHALL have parameter UPPERCASE, default 1: 1 emits "A".."F", 0 emits "a".."f".
REQ-003 SHALL have parameter SEP_CHAR, default 8'h20: byte emitted after the digits; 8'h00 means no separator.
REQ-004 SHALL have port CLK, input, 1, system clock. All logic uses posedge CLK; the block has one clock only.
REQ-005 SHALL have port RST, input, 1, reset. RST is synchronous and active-high.
REQ-006 SHALL have port in_data, input, 4*NIBBLES, word to print, MS nibble first.
REQ-007 SHALL have port in_valid, input, 1, in_data offered.
REQ-008 SHALL have port in_ready, output, 1, block can accept a word.
REQ-009 SHALL have port tx_data, output, 8, ASCII byte to the UART transmitter.
REQ-010 SHALL have port tx_enable, output, 1, start request to the UART transmitter.
REQ-011 SHALL have port tx_busy, input, 1, UART transmitter busy.
REQ-012 SHALL have port busy, output, 1, word emission in progress.
REQ-013 SHALL have port word_done, output, 1, one-cycle pulse after the last byte of a word completes.

Function
REQ-014 SHALL implement states IDLE, ISSUE and WAIT.
REQ-015 In IDLE: in_ready=1, busy=0, tx_enable=0, tx_data=0.
REQ-016 In IDLE, when in_valid=1, SHALL capture in_data into a shift register, clear the char index, and go to ISSUE; the accept cycle is T.
REQ-017 tx_enable SHALL first rise in cycle T+1.
REQ-018 In ISSUE: tx_enable=1 and tx_data=current char; on tx_busy=1 the block SHALL go to WAIT.
REQ-019 In WAIT: tx_enable=0 and tx_data held; on tx_busy=0 it SHALL advance the char index.
- If chars remain, it SHALL go to ISSUE.
- Otherwise it SHALL go to IDLE and pulse word_done for one cycle.
REQ-020 tx_data SHALL stay stable from entry into ISSUE until exit from WAIT.
REQ-021 The char sequence per word SHALL be: NIBBLES hex digits (MS first), then SEP_CHAR if it is nonzero, then the optional CR/LF (REQ-029).
REQ-022 If tx_busy is already 1 on entry to ISSUE, the block SHALL go straight to WAIT, and tx_enable SHALL be high for exactly that one cycle.
REQ-023 in_ready SHALL be 0 in ISSUE and WAIT; in_valid there SHALL be ignored without any capture.
- Back-to-back words: the next accept occurs in the IDLE cycle following word_done.
REQ-024 busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE.
REQ-025 The char index SHALL be wide enough for NIBBLES+3 chars with no wrap-around within a word.
- It SHALL reset to 0 on every accept.

Reset
REQ-026 RST=1 SHALL force, at the next edge regardless of state: state=IDLE, shift register=0, index=0, tx_enable=0, word_done=0, busy=0.
REQ-027 An in-flight word SHALL be discarded on reset and not resumed.
- The first word after reset starts at its MS digit.
REQ-028 in_valid during RST=1 SHALL NOT be accepted.

Configuration
REQ-029 Macro HEX_WORD_TX_CRLF_EN:
- Defined: 8'h0D then 8'h0A SHALL be appended after the separator of every word.
- Undefined: no CR/LF logic or index range SHALL exist, and the sequence ends after the separator.

Structure
REQ-030 Package hex_tx_pkg SHALL hold the state enum/encoding and the ASCII constants CR=8'h0D, LF=8'h0A, SP=8'h20, "0", "A" and "a".
REQ-031 Sub-module hex_digit_enc SHALL map a 4-bit nibble to ASCII, with the case selected by parameter UPPERCASE.
- It SHALL be instantiated once.

Verification
REQ-032 NIBBLES=4, in_data=16'hBEEF, UART model busy 10 cycles per byte:
- Required output: 0x42,0x45,0x45,0x46,0x20, then one word_done pulse.
- tx_enable rises at T+1.
REQ-033 UPPERCASE=0, NIBBLES=2, SEP_CHAR=0, in_data=8'h0A:
- Required output: 0x30,0x61, with no separator.
REQ-034 in_valid held high with 16'h1234 then 16'hABCD:
- Required output: "1234 ABCD ".
- in_ready SHALL be 0 throughout each word, and there SHALL be no duplicated or dropped word.
REQ-035 RST pulsed after 2 chars of 16'hBEEF:
- Next cycle: tx_enable=0, in_ready=1.
- The next word 16'h0001 SHALL emit "0001 " from its first digit.
REQ-036 tx_busy held 1 for 1000 cycles during WAIT:
- No further tx_enable and tx_data unchanged while tx_busy=1.
- Sequence resumes after tx_busy falls.
REQ-037 With HEX_WORD_TX_CRLF_EN defined, in_data=16'h00FF:
- Required output: 0x30,0x30,0x46,0x46,0x20,0x0D,0x0A.
